// File: rtl/dvp_raw_tx.sv
// OV5640-style RAW8 DVP source: programmable frame timing and Bayer test patterns.
// Every output is registered; the counters describe the cycle the outputs are showing.
module dvp_raw_tx #(
  parameter int unsigned H_ACTIVE    = 1920,
  parameter int unsigned H_BLANK     = 280,
  parameter int unsigned V_ACTIVE    = 1080,
  parameter int unsigned VSYNC_LINES = 4,
  parameter int unsigned VBP_LINES   = 16,
  parameter int unsigned VFP_LINES   = 8,
  parameter bit          VSYNC_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned HTot  = H_ACTIVE + H_BLANK;
  localparam int unsigned HW    = ($clog2(HTot) > 4) ? $clog2(HTot) : 4;
  localparam int unsigned LMax0 = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int unsigned LMax1 = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int unsigned LMax  = (LMax0 > LMax1) ? LMax0 : LMax1;
  localparam int unsigned LW    = ($clog2(LMax) > 4) ? $clog2(LMax) : 4;
  localparam int unsigned BarW  = H_ACTIVE / 8;
  localparam int unsigned SW    = (BarW > 1) ? $clog2(BarW) : 1;

  localparam logic [HW-1:0] HLast   = HW'(HTot - 1);
  localparam logic [HW-1:0] HActEnd = HW'(H_ACTIVE);
  localparam logic [LW-1:0] VfpLast = LW'(VFP_LINES - 1);
  localparam logic [SW-1:0] SubLast = SW'(BarW - 1);

  typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [2:0]    bar_q, bar_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [LW-1:0] lines_last;
  logic [7:0]    xb;

  always_comb begin
    lines_last = VfpLast;
    case (state_q)
      StVsync:  lines_last = LW'(VSYNC_LINES - 1);
      StVbp:    lines_last = LW'(VBP_LINES - 1);
      StActive: lines_last = LW'(V_ACTIVE - 1);
      default:  lines_last = VfpLast;
    endcase
  end

  // Raster position of the next cycle.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    sel_d   = sel_q;
    if (state_q == StIdle) begin
      hcnt_d = '0;
      lcnt_d = '0;
      if (enable) begin
        state_d = StVsync;
        sel_d   = pattern_sel;
      end
    end else if (hcnt_q == HLast) begin
      hcnt_d = '0;
      if (lcnt_q == lines_last) begin
        lcnt_d = '0;
        case (state_q)
          StVsync:  state_d = StVbp;
          StVbp:    state_d = StActive;
          StActive: state_d = StVfp;
          default: begin
            if (enable) begin
              state_d = StVsync;
              sel_d   = pattern_sel;
            end else begin
              state_d = StIdle;
            end
          end
        endcase
      end else begin
        lcnt_d = lcnt_q + LW'(1);
      end
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  // Colour-bar index tracks x with a sub-counter so no divider is needed.
  always_comb begin
    sub_d = sub_q;
    bar_d = bar_q;
    if (hcnt_d == '0) begin
      sub_d = '0;
      bar_d = '0;
    end else if (sub_q == SubLast) begin
      sub_d = '0;
      bar_d = bar_q + 3'd1;
    end else begin
      sub_d = sub_q + SW'(1);
    end
  end

  always_comb begin
    xb           = 8'(hcnt_d);
    vsync_d      = (state_d == StVsync) ? VSYNC_POL : ~VSYNC_POL;
    href_d       = (state_d == StActive) && (hcnt_d < HActEnd);
    frame_done_d = (state_d == StVfp) && (lcnt_d == VfpLast) && (hcnt_d == HLast);
    frame_cnt_d  = frame_cnt_q + 16'(frame_done_d);
    data_d       = 8'h00;
    if (href_d) begin
      case (sel_d)
        2'd0: data_d = xb;
        2'd1: begin
          case ({lcnt_d[0], xb[0]})
            2'b00:   data_d = {8{bar_d[2]}};
            2'b11:   data_d = {8{bar_d[0]}};
            default: data_d = {8{bar_d[1]}};
          endcase
        end
        2'd2:    data_d = {8{xb[3] ^ lcnt_d[3]}};
        default: data_d = frame_cnt_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      sel_q        <= '0;
      sub_q        <= '0;
      bar_q        <= '0;
      vsync_q      <= ~VSYNC_POL;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      sel_q        <= sel_d;
      sub_q        <= sub_d;
      bar_q        <= bar_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dvp_raw_tx.sv
// Bench for dvp_raw_tx: a small raster model predicts every output on every cycle of each frame.
module tb_dvp_raw_tx;

  localparam int HA  = 8;
  localparam int HB  = 4;
  localparam int VA  = 4;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int HT  = HA + HB;
  localparam int FL  = HT * (VS + VBP + VA + VFP);

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int          tests = 0;
  int          fails = 0;
  int          fc = 0;
  logic [1:0]  lat_sel = 2'd0;

  dvp_raw_tx #(
    .H_ACTIVE   (HA),
    .H_BLANK    (HB),
    .V_ACTIVE   (VA),
    .VSYNC_LINES(VS),
    .VBP_LINES  (VBP),
    .VFP_LINES  (VFP),
    .VSYNC_POL  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected pixel straight from the pattern definitions.
  function automatic logic [7:0] pix(input logic [1:0] sel, input int x, input int y, input int f);
    int b;
    int site;
    bit on;
    case (sel)
      2'd0: return 8'(x % 256);
      2'd1: begin
        b    = x / (HA / 8);
        site = (y % 2) * 2 + (x % 2);
        if (site == 0)      on = ((b / 4) % 2) == 1;
        else if (site == 3) on = (b % 2) == 1;
        else                on = ((b / 2) % 2) == 1;
        return on ? 8'hFF : 8'h00;
      end
      2'd2:    return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      default: return 8'(f % 256);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input int k, output bit act, output bit done);
    int line;
    int h;
    int ay;
    line = k / HT;
    h    = k % HT;
    ay   = line - VS - VBP;
    act  = (ay >= 0) && (ay < VA) && (h < HA);
    done = (k == FL - 1);
    chk("vsync", 16'(vsync), 16'(line < VS));
    chk("href", 16'(href), 16'(act));
    chk("data", 16'(data), 16'(act ? pix(lat_sel, h, ay, fc) : 8'h00));
    chk("frame_done", 16'(frame_done), 16'(done));
    chk("frame_cnt", frame_cnt, 16'(done ? fc + 1 : fc));
  endtask

  // Entered on the first cycle of a frame; last_k < FL-1 stops early without ticking.
  task automatic do_frame(input int drop_at, input logic next_en, input logic [1:0] next_sel,
                          input int last_k);
    int  nvs = 0;
    int  nhref = 0;
    int  nfd = 0;
    bit  act;
    bit  done;
    for (int k = 0; k <= last_k; k++) begin
      check_pos(k, act, done);
      if (vsync === 1'b1) nvs++;
      if (href === 1'b1) nhref++;
      if (frame_done === 1'b1) nfd++;
      if (k == last_k && last_k < FL - 1) return;
      if (k == FL - 1) begin
        enable      = next_en;
        pattern_sel = next_sel;
      end else begin
        pattern_sel = 2'($urandom);
        enable      = (drop_at >= 0) ? (k < drop_at) : 1'($urandom);
      end
      tick();
    end
    chk("vsync_cycles", 16'(nvs), 16'(HT * VS));
    chk("href_cycles", 16'(nhref), 16'(HA * VA));
    chk("done_pulses", 16'(nfd), 16'd1);
    fc++;
    if (next_en) lat_sel = next_sel;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_vsync", 16'(vsync), 16'd0);
      chk("idle_href", 16'(href), 16'd0);
      chk("idle_data", 16'(data), 16'd0);
      chk("idle_done", 16'(frame_done), 16'd0);
      chk("idle_cnt", frame_cnt, 16'(fc));
      enable      = 1'b0;
      pattern_sel = 2'($urandom);
      tick();
    end
  endtask

  initial begin
    logic [1:0] rs;
    reset       = 1'b1;
    enable      = 1'b1;
    pattern_sel = 2'd0;

    // Reset held with enable high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_vsync", 16'(vsync), 16'd0);
      chk("rst_href", 16'(href), 16'd0);
      chk("rst_data", 16'(data), 16'd0);
      chk("rst_done", 16'(frame_done), 16'd0);
      chk("rst_cnt", frame_cnt, 16'd0);
    end
    reset   = 1'b0;
    lat_sel = 2'd0;
    tick();

    // Ramp timing, two back-to-back frames.
    do_frame(-1, 1'b1, 2'd0, FL - 1);
    do_frame(-1, 1'b1, 2'd1, FL - 1);
    // Colour bars.
    do_frame(-1, 1'b1, 2'd2, FL - 1);
    // Checker, then frame-count fill showing 05.
    do_frame(-1, 1'b1, 2'd2, FL - 1);
    do_frame(-1, 1'b1, 2'd3, FL - 1);
    rs = 2'($urandom);
    do_frame(-1, 1'b1, rs, FL - 1);
    for (int i = 0; i < 2; i++) begin
      rs = 2'($urandom);
      do_frame(-1, 1'b1, rs, FL - 1);
    end

    // Enable dropped mid-frame: frame still completes, then IDLE.
    rs = 2'($urandom);
    do_frame(30, 1'b0, rs, FL - 1);
    idle_check(20);

    // Reset while x=3 on the first active line.
    enable      = 1'b1;
    pattern_sel = 2'd0;
    lat_sel     = 2'd0;
    tick();
    do_frame(-1, 1'b1, 2'd0, HT * (VS + VBP) + 3);
    chk("pre_rst_href", 16'(href), 16'd1);
    reset = 1'b1;
    tick();
    fc = 0;
    chk("midrst_href", 16'(href), 16'd0);
    chk("midrst_data", 16'(data), 16'd0);
    chk("midrst_cnt", frame_cnt, 16'd0);
    chk("midrst_vsync", 16'(vsync), 16'd0);
    chk("midrst_done", 16'(frame_done), 16'd0);
    reset       = 1'b0;
    enable      = 1'b1;
    rs          = 2'($urandom);
    pattern_sel = rs;
    lat_sel     = rs;
    tick();
    do_frame(-1, 1'b0, 2'd0, FL - 1);
    idle_check(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
